// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - parametrised UART transmitter: control FSM, baud counter, shift register, line driver
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 8,
    parameter int COUNTER_SIZE = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state;
    logic [COUNTER_SIZE-1:0] baud_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [DATA_BITS-1:0]    shreg;
    logic                    parity_bit;
    logic                    stop_cnt;
    logic                    bit_end;

    // Last clock of the current bit period
    assign bit_end = (baud_cnt == COUNTER_SIZE'(CLKS_PER_BIT - 1));

    // Frame sequencer; tx, busy and done are all driven straight from flops
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            stop_cnt   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    stop_cnt <= 1'b0;
                    if (send) begin
                        state      <= START;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        shreg      <= data;
                        parity_bit <= (^data) ^ (PARITY_ODD != 0);
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx       <= shreg[0];
                        shreg    <= shreg >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + COUNTER_SIZE'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + COUNTER_SIZE'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + COUNTER_SIZE'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            stop_cnt <= 1'b0;
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + COUNTER_SIZE'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    stop_cnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed table-driven bench for uart_tx_engine
module tb_uart_tx_engine;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] send  = 4'b0000;
    logic [7:0] data  = 8'h00;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    // 0: 8N1   1: 8E1   2: 8O1   3: 8N2
    uart_tx_engine #(.CLKS_PER_BIT(CPB), .COUNTER_SIZE(4), .DATA_BITS(8),
                     .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
        .clock(clock), .reset(reset), .send(send[0]), .data(data),
        .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    uart_tx_engine #(.CLKS_PER_BIT(CPB), .COUNTER_SIZE(4), .DATA_BITS(8),
                     .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e1 (
        .clock(clock), .reset(reset), .send(send[1]), .data(data),
        .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    uart_tx_engine #(.CLKS_PER_BIT(CPB), .COUNTER_SIZE(4), .DATA_BITS(8),
                     .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_o1 (
        .clock(clock), .reset(reset), .send(send[2]), .data(data),
        .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    uart_tx_engine #(.CLKS_PER_BIT(CPB), .COUNTER_SIZE(4), .DATA_BITS(8),
                     .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_n2 (
        .clock(clock), .reset(reset), .send(send[3]), .data(data),
        .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    typedef struct {
        int          sel;
        logic [7:0]  d;
        logic [11:0] frame;   // line bits, element 0 sent first
        int          nbits;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int t, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d actual=%b required=%b", name, t, act, exp);
        end
    endtask

    // Send one frame on instance sel and check every cycle through the done pulse.
    // poke >= 0 pulses send with data=0 at that cycle while the frame is busy.
    task automatic run_frame(input int sel, input logic [7:0] d, input logic [11:0] frame,
                             input int nbits, input int poke);
        int f;
        f = nbits * CPB;
        @(negedge clock);
        data      = d;
        send[sel] = 1'b1;
        @(negedge clock);
        send[sel] = 1'b0;
        for (int t = 0; t <= f; t++) begin
            if (t < f) begin
                check("tx_bit", t, tx_v[sel], frame[t / CPB]);
                check("busy_hi", t, busy_v[sel], 1'b1);
                check("done_lo", t, done_v[sel], 1'b0);
            end else begin
                check("tx_end", t, tx_v[sel], 1'b1);
                check("busy_end", t, busy_v[sel], 1'b0);
                check("done_pulse", t, done_v[sel], 1'b1);
            end
            if (t == poke) begin
                send[sel] = 1'b1;
                data      = 8'h00;
            end else if (t == poke + 1) begin
                send[sel] = 1'b0;
            end
            @(negedge clock);
        end
        for (int k = 0; k < 4; k++) begin
            check("idle_done", f + 1 + k, done_v[sel], 1'b0);
            check("idle_busy", f + 1 + k, busy_v[sel], 1'b0);
            check("idle_tx", f + 1 + k, tx_v[sel], 1'b1);
            @(negedge clock);
        end
    endtask

    initial begin
        logic [9:0] f3c;
        int         p;

        vecs[0] = '{0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
        vecs[1] = '{0, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0}, 10};
        vecs[2] = '{0, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0}, 10};
        vecs[3] = '{1, 8'hA5, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};
        vecs[4] = '{2, 8'hA5, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};
        vecs[5] = '{1, 8'h01, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11};
        vecs[6] = '{2, 8'h01, {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11};
        vecs[7] = '{3, 8'hFF, {1'b0, 2'b11, 8'hFF, 1'b0}, 11};
        vecs[8] = '{3, 8'h3C, {1'b0, 2'b11, 8'h3C, 1'b0}, 11};

        // Reset state
        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            check("rst_tx", i, tx_v[i], 1'b1);
            check("rst_busy", i, busy_v[i], 1'b0);
            check("rst_done", i, done_v[i], 1'b0);
        end
        reset = 1'b0;
        @(negedge clock);

        // Table vectors
        for (int v = 0; v < 9; v++)
            run_frame(vecs[v].sel, vecs[v].d, vecs[v].frame, vecs[v].nbits, -1);

        // send while busy is ignored
        run_frame(0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 10);

        // Reset mid-DATA at E0+17
        @(negedge clock);
        data    = 8'hA5;
        send[0] = 1'b1;
        @(negedge clock);
        send[0] = 1'b0;
        repeat (16) @(negedge clock);
        check("pre_rst_busy", 16, busy_v[0], 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_tx", 17, tx_v[0], 1'b1);
        check("mid_rst_busy", 17, busy_v[0], 1'b0);
        check("mid_rst_done", 17, done_v[0], 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_done", 18, done_v[0], 1'b0);
        run_frame(0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, -1);

        // send held high: frames repeat with one idle-high clock between them
        f3c = {1'b1, 8'h3C, 1'b0};
        @(negedge clock);
        data    = 8'h3C;
        send[0] = 1'b1;
        @(negedge clock);
        for (int t = 0; t < 3 * 41; t++) begin
            p = t % 41;
            if (p < 40) begin
                check("b2b_tx", t, tx_v[0], f3c[p / CPB]);
                check("b2b_busy", t, busy_v[0], 1'b1);
                check("b2b_done", t, done_v[0], 1'b0);
            end else begin
                check("b2b_gap_tx", t, tx_v[0], 1'b1);
                check("b2b_gap_busy", t, busy_v[0], 1'b0);
                check("b2b_gap_done", t, done_v[0], 1'b1);
            end
            @(negedge clock);
        end
        send[0] = 1'b0;
        repeat (45) @(negedge clock);
        check("final_busy", 0, busy_v[0], 1'b0);
        check("final_tx", 0, tx_v[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmitter that generalises the fixed 8-bit, 10-bit-frame TX control path into a single block. It contains the control FSM, baud counter, shift register and line driver. Data width, optional even/odd parity and 1 or 2 stop bits are configurable. A send/busy/done handshake sits toward the host logic, and the serial line is driven directly from a register.

Parameters:
CLKS_PER_BIT, 8, clock cycles per serial bit; must be >= 2.
COUNTER_SIZE, 8, baud counter width; 2^COUNTER_SIZE >= CLKS_PER_BIT.
DATA_BITS, 8, payload width; legal range 5..9.
PARITY_EN, 0, 1 inserts one parity bit after the data.
PARITY_ODD, 0, parity type when PARITY_EN=1: 0 = even, 1 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clock  input  1  single clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
send  input  1  start request; sampled only in IDLE.
data  input  DATA_BITS  payload; captured on the edge that accepts send.
tx  output  1  serial line; registered; idles high.
busy  output  1  high while a frame is in progress (state != IDLE).
done  output  1  one-cycle pulse on the first IDLE cycle after a frame.

Behaviour:
- Reset (reset=1 at an edge): state=IDLE, tx=1, busy=0, done=0, counters=0, shift register=0. Reset overrides everything, including a frame in progress. Partial frames are abandoned; tx returns high on the next cycle with no stop bit.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when send=1.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (if PARITY_EN) or STOP after DATA_BITS bit periods.
  - PARITY -> STOP after one bit period.
  - STOP -> IDLE after STOP_BITS bit periods.
- Acceptance: send=1 sampled in IDLE at edge E0.
  - At E0, data is latched and the parity bit is computed from the latched word.
  - From E0 on: tx=0 and busy=1.
  - send while busy is ignored; data changes after E0 have no effect.
- Bit timing: each bit holds tx for exactly CLKS_PER_BIT clocks. The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Data bits are sent LSB first.
- Parity bit = XOR of the DATA_BITS data bits, inverted when PARITY_ODD=1.
- Stop bits: tx=1.
- Frame length: F = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT clocks.
- Frame completion: at edge E0+F, state=IDLE, busy=0, done=1 for exactly one cycle, tx=1.
- Back-to-back frames:
  - If send=1 during the done cycle, it is accepted at edge E0+F+1.
  - The minimum inter-frame gap is one extra idle-high clock, so stop time is at least STOP_BITS*CLKS_PER_BIT + 1 clocks.
- Counter widths: the bit index counter is wide enough for DATA_BITS-1 and wraps to 0 on the DATA->next transition.
- No X on outputs after the first reset. Unused or illegal state encodings recover to IDLE with tx=1 on the next edge.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, no parity, 1 stop; send data=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; busy high 40 cycles; done pulses once at E0+40.
2. PARITY_EN=1: 0xA5 with PARITY_ODD=0 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; frame is 44 clocks.
3. STOP_BITS=2, data=0xFF -> start 0, eight 1s, then tx high for 8 clocks before done at E0+44 (CLKS_PER_BIT=4).
4. send pulsed at E0+10 with data=0x00 while busy -> ignored; line still carries 0xA5; exactly one done pulse.
5. reset asserted at E0+17 (mid-DATA) -> next cycle tx=1, busy=0, done=0; a send after reset releases yields a clean full frame.
6. send held high continuously with data=0x3C -> frames repeat with tx high exactly 1 extra clock between stop and next start; each frame carries 0x3C.
